gmii_rx_frame: RTL and testbench

- Receive MAC framer sitting directly downstream of the RGMII-to-GMII receive converter, clocked by its GMII receive clock.
- Strips preamble/SFD and checks the Ethernet FCS (CRC-32).
- Evaluates the destination MAC against the local or broadcast address.
- Streams frame bytes (dst MAC through last payload byte, FCS removed) to the packet parser with sop/eop framing plus a per-frame good/bad verdict and length.

---
 rtl/eth_rx_pkg.sv | 39 +++
 rtl/crc32_d8.sv | 28 ++
 rtl/gmii_rx_frame.sv | 192 +++++++++++++++++++
 tb/tb_gmii_rx_frame.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared Ethernet receive constants, FSM encoding and CRC/MAC helper functions.
package eth_rx_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;

  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;

  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

  localparam int unsigned MAC_BYTES    = 6;
  // Bytes held back so the trailing FCS never reaches the consumer.
  localparam int unsigned DLY_DEPTH    = 5;

  localparam logic [1:0]  ST_IDLE      = 2'd0;
  localparam logic [1:0]  ST_PRE       = 2'd1;
  localparam logic [1:0]  ST_DATA      = 2'd2;
  localparam logic [1:0]  ST_DROP      = 2'd3;

  // Reflected CRC-32, one byte, LSB of the byte first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Wire-order byte idx of a MAC address (idx 0 = mac[47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << (8 * idx);
    return sh[47:40];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register with synchronous init and enable; shared by RX check and TX FCS.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_nxt;

  assign crc_nxt = crc32_next(crc, data);

  // NOTE: state registers use <= so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks FCS and destination MAC,
// streams dst..payload bytes with sop/eop and a per-frame verdict.
module gmii_rx_frame
  import eth_rx_pkg::*;
#(
  parameter bit          FILTER_EN = 1'b1,
  parameter int unsigned PRE_MIN   = 1,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic [47:0] local_mac,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        frame_done,
  output logic        frame_good,
  output logic        mac_hit,
  output logic [15:0] frame_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  logic [1:0]  state;
  logic        armed;
  logic [2:0]  pre_cnt;
  logic [15:0] len;
  logic        loc_eq;
  logic        bc_eq;
  logic [7:0]  dly [DLY_DEPTH];
  logic [2:0]  dly_cnt;
  logic        first_out;
  logic [31:0] crc;

  logic start_frame;
  logic data_beat;
  logic end_evt;
  logic dly_full;
  logic crc_ok;
  logic len_ok;
  logic hit_now;
  logic good_now;

  assign start_frame = (state == ST_PRE) && gmii_rx_dv && (gmii_rxd == ETH_SFD)
                       && (32'(pre_cnt) >= PRE_MIN);
  assign data_beat   = (state == ST_DATA) && gmii_rx_dv;
  assign end_evt     = (state == ST_DATA) && !gmii_rx_dv;
  assign dly_full    = (dly_cnt == 3'(DLY_DEPTH));

  assign crc_ok   = (crc == CRC_RESIDUE);
  assign len_ok   = (32'(len) >= MIN_LEN) && (32'(len) <= MAX_LEN);
  assign hit_now  = (32'(len) >= MAC_BYTES) && (loc_eq || bc_eq);
  assign good_now = crc_ok && len_ok && (hit_now || !FILTER_EN);

  crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (start_frame),
    .en    (data_beat),
    .data  (gmii_rxd),
    .crc   (crc)
  );

  // Receive state machine; after reset nothing is accepted until dv has been low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      armed   <= 1'b0;
      pre_cnt <= '0;
    end else begin
      if (!gmii_rx_dv) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (gmii_rx_dv && armed) begin
            if (gmii_rxd == ETH_PREAMBLE) begin
              state   <= ST_PRE;
              pre_cnt <= 3'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (!gmii_rx_dv) begin
            state <= ST_IDLE;
          end else if (gmii_rxd == ETH_PREAMBLE) begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
          end else if (start_frame) begin
            state <= ST_DATA;
          end else begin
            state <= ST_DROP;
          end
        end
        ST_DATA: if (!gmii_rx_dv) state <= ST_IDLE;
        ST_DROP: if (!gmii_rx_dv) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Length and destination-address tracking for the frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len    <= '0;
      loc_eq <= 1'b0;
      bc_eq  <= 1'b0;
    end else if (start_frame) begin
      len    <= '0;
      loc_eq <= 1'b1;
      bc_eq  <= 1'b1;
    end else if (data_beat) begin
      if (len != 16'hFFFF) len <= len + 16'd1;
      if (32'(len) < MAC_BYTES) begin
        loc_eq <= loc_eq && (gmii_rxd == mac_byte(local_mac, len[2:0]));
        bc_eq  <= bc_eq  && (gmii_rxd == mac_byte(BCAST_MAC, len[2:0]));
      end
    end
  end

  // Delay line: a byte is released only once five newer bytes exist, so the
  // four FCS bytes (plus the eop byte) are still inside it at END.
  // NOTE: the 5-entry delay line is plain flops, not RAM, so it takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY_DEPTH; i++) dly[i] <= '0;
      dly_cnt   <= '0;
      first_out <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      if (start_frame) begin
        dly_cnt   <= '0;
        first_out <= 1'b1;
      end else if (data_beat) begin
        dly[0] <= gmii_rxd;
        for (int i = 1; i < DLY_DEPTH; i++) dly[i] <= dly[i-1];
        if (dly_full) begin
          out_valid <= 1'b1;
          out_data  <= dly[DLY_DEPTH-1];
          out_sop   <= first_out;
          first_out <= 1'b0;
        end else begin
          dly_cnt <= dly_cnt + 3'd1;
        end
      end else if (end_evt) begin
        dly_cnt   <= '0;
        first_out <= 1'b0;
        if (dly_full) begin
          out_valid <= 1'b1;
          out_data  <= dly[DLY_DEPTH-1];
          out_sop   <= first_out;
          out_eop   <= 1'b1;
        end
      end
    end
  end

  // Verdict and saturating statistics, all updated on the END edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      mac_hit    <= 1'b0;
      frame_len  <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (end_evt) begin
        frame_done <= 1'b1;
        frame_good <= good_now;
        mac_hit    <= hit_now;
        frame_len  <= len;
        if (good_now) begin
          if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
        end else begin
          if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Self-checking bench for gmii_rx_frame: table of frames plus preamble-error and reset sequences.
module tb_gmii_rx_frame;

  localparam logic [47:0] LOC_MAC  = 48'h0011_2233_4455;
  localparam logic [47:0] BC_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MISS_MAC = 48'h0011_2233_4456;

  typedef struct {
    string       name;
    logic [47:0] dst;
    int          len;      // bytes after SFD including FCS
    int          pre;      // number of 0x55 bytes
    bit          bad_fcs;
    bit          good;     // expected verdict, FILTER_EN=1
    bit          hit;
    bit          nf_good;  // expected verdict, FILTER_EN=0
  } case_t;

  typedef struct {
    logic [7:0] data;
    bit         sop;
    bit         eop;
    int         cyc;
  } exp_byte_t;

  typedef struct {
    bit          good;
    bit          hit;
    bit          nf_good;
    logic [15:0] len;
    int          cyc;
  } exp_verd_t;

  logic        clk;
  logic        rst_n;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic [47:0] local_mac;

  logic        out_valid, out_sop, out_eop, frame_done, frame_good, mac_hit;
  logic [7:0]  out_data;
  logic [15:0] frame_len, good_cnt, bad_cnt;

  logic        nf_out_valid, nf_out_sop, nf_out_eop, nf_frame_done, nf_frame_good, nf_mac_hit;
  logic [7:0]  nf_out_data;
  logic [15:0] nf_frame_len, nf_good_cnt, nf_bad_cnt;

  gmii_rx_frame #(.FILTER_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rxd   (gmii_rxd),
    .local_mac  (local_mac),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .frame_done (frame_done),
    .frame_good (frame_good),
    .mac_hit    (mac_hit),
    .frame_len  (frame_len),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  gmii_rx_frame #(.FILTER_EN(1'b0)) dut_nf (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rxd   (gmii_rxd),
    .local_mac  (local_mac),
    .out_valid  (nf_out_valid),
    .out_data   (nf_out_data),
    .out_sop    (nf_out_sop),
    .out_eop    (nf_out_eop),
    .frame_done (nf_frame_done),
    .frame_good (nf_frame_good),
    .mac_hit    (nf_mac_hit),
    .frame_len  (nf_frame_len),
    .good_cnt   (nf_good_cnt),
    .bad_cnt    (nf_bad_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_good = 0, exp_bad = 0, exp_nf_good = 0, exp_nf_bad = 0;
  string       cur_name = "reset";
  logic [7:0]  frm[$];
  exp_byte_t   byte_q[$];
  exp_verd_t   verd_q[$];
  case_t       cases[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s] cycle %0d: got 0x%0h, expected 0x%0h", name, cur_name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input case_t c);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [47:0] dst;
    int          nd;
    frm.delete();
    dst = c.dst;
    nd  = (c.len >= 4) ? c.len - 4 : c.len;
    for (int i = 0; i < nd; i++) begin
      logic [7:0] b;
      if (i < 6)       b = dst[47 - 8*i -: 8];
      else if (i < 12) b = (i == 6) ? 8'h02 : 8'(i);
      else if (i == 12) b = 8'h08;
      else if (i == 13) b = 8'h06;
      else             b = 8'(i * 7 + 3);
      frm.push_back(b);
    end
    if (c.len >= 4) begin
      crc = 32'hFFFF_FFFF;
      foreach (frm[i]) crc = crc_upd(crc, frm[i]);
      fcs = ~crc;
      if (c.bad_fcs) fcs[9] = ~fcs[9];
      for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    @(negedge clk);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
  endtask

  // Byte n sampled at edge cyc+1 must appear five edges later; END verdict one edge after sampling.
  task automatic send_frame(input case_t c, input int gap);
    exp_verd_t v;
    cur_name = c.name;
    build_frame(c);
    for (int p = 0; p < c.pre; p++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < c.len; i++) begin
      drive(1'b1, frm[i]);
      if (c.len >= 5 && i <= c.len - 5)
        byte_q.push_back('{frm[i], i == 0, i == c.len - 5, cyc + 6});
    end
    drive(1'b0, 8'h00);
    v = '{c.good, c.hit, c.nf_good, 16'(c.len), cyc + 1};
    verd_q.push_back(v);
    for (int g = 1; g < gap; g++) drive(1'b0, 8'h00);
  endtask

  // Scoreboard: pop expected bytes and verdicts as the DUT produces them.
  always @(negedge clk) begin : monitor
    exp_byte_t e;
    exp_verd_t v;
    while (byte_q.size() > 0 && byte_q[0].cyc < cyc) begin
      e = byte_q.pop_front();
      check("out byte overdue, expected at cycle", 32'(cyc), 32'(e.cyc));
    end
    while (verd_q.size() > 0 && verd_q[0].cyc < cyc) begin
      v = verd_q.pop_front();
      check("frame_done overdue, expected at cycle", 32'(cyc), 32'(v.cyc));
    end
    if (out_valid) begin
      if (byte_q.size() == 0) begin
        check("spurious out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = byte_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sop", 32'(out_sop), 32'(e.sop));
        check("out_eop", 32'(out_eop), 32'(e.eop));
        check("out byte cycle", 32'(cyc), 32'(e.cyc));
        check("nf out_valid", 32'(nf_out_valid), 32'd1);
        check("nf out_data", 32'(nf_out_data), 32'(e.data));
        check("nf out_sop/eop", {30'd0, nf_out_sop, nf_out_eop}, {30'd0, e.sop, e.eop});
      end
    end else if (out_sop || out_eop) begin
      check("sop/eop without out_valid", {30'd0, out_sop, out_eop}, 32'd0);
    end
    if (frame_done) begin
      if (verd_q.size() == 0) begin
        check("spurious frame_done", 32'(frame_done), 32'd0);
      end else begin
        v = verd_q.pop_front();
        if (v.good) exp_good++; else exp_bad++;
        if (v.nf_good) exp_nf_good++; else exp_nf_bad++;
        check("frame_good", 32'(frame_good), 32'(v.good));
        check("mac_hit", 32'(mac_hit), 32'(v.hit));
        check("frame_len", 32'(frame_len), 32'(v.len));
        check("frame_done cycle", 32'(cyc), 32'(v.cyc));
        check("good_cnt", 32'(good_cnt), 32'(exp_good));
        check("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
        check("nf frame_done", 32'(nf_frame_done), 32'd1);
        check("nf frame_good", 32'(nf_frame_good), 32'(v.nf_good));
        check("nf mac_hit", 32'(nf_mac_hit), 32'(v.hit));
        check("nf frame_len", 32'(nf_frame_len), 32'(v.len));
        check("nf good_cnt", 32'(nf_good_cnt), 32'(exp_nf_good));
        check("nf bad_cnt", 32'(nf_bad_cnt), 32'(exp_nf_bad));
      end
    end else if (nf_frame_done) begin
      check("nf spurious frame_done", 32'(nf_frame_done), 32'd0);
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, " out_valid"},  32'(out_valid), 32'd0);
    check({tag, " out_data"},   32'(out_data), 32'd0);
    check({tag, " out_sop"},    32'(out_sop), 32'd0);
    check({tag, " out_eop"},    32'(out_eop), 32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check({tag, " frame_good"}, 32'(frame_good), 32'd0);
    check({tag, " mac_hit"},    32'(mac_hit), 32'd0);
    check({tag, " frame_len"},  32'(frame_len), 32'd0);
    check({tag, " good_cnt"},   32'(good_cnt), 32'd0);
    check({tag, " bad_cnt"},    32'(bad_cnt), 32'd0);
    check({tag, " nf good_cnt"}, 32'(nf_good_cnt), 32'd0);
    check({tag, " nf bad_cnt"},  32'(nf_bad_cnt), 32'd0);
  endtask

  initial begin
    case_t c;
    //           name               dst       len   pre bad  good hit nf
    cases[0]  = '{"bcast_arp_64",   BC_MAC,   64,   7,  1'b0, 1'b1, 1'b1, 1'b1};
    cases[1]  = '{"bcast_bad_fcs",  BC_MAC,   64,   7,  1'b1, 1'b0, 1'b1, 1'b0};
    cases[2]  = '{"dst_mismatch",   MISS_MAC, 64,   7,  1'b0, 1'b0, 1'b0, 1'b1};
    cases[3]  = '{"local_pre1",     LOC_MAC,  64,   1,  1'b0, 1'b1, 1'b1, 1'b1};
    cases[4]  = '{"runt_3",         BC_MAC,   3,    7,  1'b0, 1'b0, 1'b0, 1'b0};
    cases[5]  = '{"len65_pre10",    LOC_MAC,  65,   10, 1'b0, 1'b1, 1'b1, 1'b1};
    cases[6]  = '{"oversize_1519",  BC_MAC,   1519, 7,  1'b0, 1'b0, 1'b1, 1'b0};
    cases[7]  = '{"max_1518",       LOC_MAC,  1518, 3,  1'b0, 1'b1, 1'b1, 1'b1};
    cases[8]  = '{"short_63",       LOC_MAC,  63,   7,  1'b0, 1'b0, 1'b1, 1'b0};
    cases[9]  = '{"len5_sop_eop",   LOC_MAC,  5,    7,  1'b0, 1'b0, 1'b0, 1'b0};
    cases[10] = '{"len0",           LOC_MAC,  0,    7,  1'b0, 1'b0, 1'b0, 1'b0};

    rst_n      = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    local_mac  = LOC_MAC;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (cases[i]) send_frame(cases[i], (i % 2 == 1) ? 1 : 3);

    // Bad preamble byte: the whole burst is dropped, then a good frame one dv-low cycle later.
    cur_name = "bad_preamble";
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h5D);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int k = 0; k < 12; k++) drive(1'b1, 8'(k * 3 + 1));
    drive(1'b0, 8'h00);
    c = cases[0];
    c.name = "after_bad_preamble";
    send_frame(c, 2);

    // Reset 20 bytes into a frame: bytes 0..14 have already streamed.
    c = cases[3];
    c.name = "reset_mid_frame";
    c.pre  = 7;
    cur_name = c.name;
    build_frame(c);
    for (int p = 0; p < 7; p++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, frm[i]);
      if (i <= 14) byte_q.push_back('{frm[i], i == 0, 1'b0, cyc + 6});
    end
    drive(1'b1, frm[20]);
    #2 rst_n = 1'b0;
    exp_good    = 0;
    exp_bad     = 0;
    exp_nf_good = 0;
    exp_nf_bad  = 0;
    #1 check_all_zero("mid-frame reset");
    for (int i = 21; i < 64; i++) begin
      drive(1'b1, frm[i]);
      if (i == 23) rst_n = 1'b1;
    end
    drive(1'b0, 8'h00);
    c.name = "after_reset";
    send_frame(c, 1);

    for (int k = 0; k < 20 && (byte_q.size() > 0 || verd_q.size() > 0); k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("expected bytes left unseen", 32'(byte_q.size()), 32'd0);
    check("expected verdicts left unseen", 32'(verd_q.size()), 32'd0);
    check("final good_cnt", 32'(good_cnt), 32'd1);
    check("final bad_cnt", 32'(bad_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
